// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one ALU between
// two requesters; IDLE grants, EXEC lets the ALU settle, RESP returns.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   reqN_valid/ready/a/b/op      request channels (N = 0, 1)
//   rspN_valid/ready/result/zero response channels (N = 0, 1)
//   alu_a, alu_b, alu_control    registered operands to the ALU
//   alu_result, alu_zero         combinational ALU outputs
//   busy                         high outside IDLE
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_control,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state_q;
   logic             owner_q;
   logic             last_q;
   logic             busy_q;
   logic             rsp0_v_q;
   logic             rsp1_v_q;
   logic             zero_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [OPW-1:0]   op_q;

   logic             gnt0;
   logic             gnt1;
   logic             idle;
   logic             rsp_done;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_d;
   logic [OPW-1:0]   op_d;

   // req1 wins when alone, or on a tie when req0 was granted last.
   assign gnt1 = req1_valid & (~req0_valid | ~last_q);
   assign gnt0 = req0_valid & ~gnt1;

   // Gated by rst_n so no ready escapes while reset is held.
   assign idle       = (state_q == IDLE) & rst_n;
   assign req0_ready = idle & gnt0;
   assign req1_ready = idle & gnt1;

   assign a_d  = gnt1 ? req1_a  : req0_a;
   assign b_d  = gnt1 ? req1_b  : req0_b;
   assign op_d = gnt1 ? req1_op : req0_op;

   assign rsp_done = owner_q ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         busy_q   <= 1'b0;
         rsp0_v_q <= 1'b0;
         rsp1_v_q <= 1'b0;
         zero_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         op_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gnt0 | gnt1) begin
                  a_q     <= a_d;
                  b_q     <= b_d;
                  op_q    <= op_d;
                  owner_q <= gnt1;
                  last_q  <= gnt1;
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q    <= alu_result;
               zero_q   <= alu_zero;
               rsp0_v_q <= ~owner_q;
               rsp1_v_q <= owner_q;
               state_q  <= RESP;
            end
            RESP: begin
               if (rsp_done) begin
                  rsp0_v_q <= 1'b0;
                  rsp1_v_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_control = op_q;
   assign rsp0_valid  = rsp0_v_q;
   assign rsp1_valid  = rsp1_v_q;
   assign rsp0_result = res_q;
   assign rsp1_result = res_q;
   assign rsp0_zero   = zero_q;
   assign rsp1_zero   = zero_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized bench for alu_arbiter with an ALU model
// and a transaction-level reference (grant pointer + ALU function).
module tb_alu_arbiter;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req0_ready;
   logic [W-1:0] req0_a, req0_b;
   logic [3:0]   req0_op;
   logic         req1_valid, req1_ready;
   logic [W-1:0] req1_a, req1_b;
   logic [3:0]   req1_op;
   logic         rsp0_valid, rsp0_ready, rsp0_zero;
   logic [W-1:0] rsp0_result;
   logic         rsp1_valid, rsp1_ready, rsp1_zero;
   logic [W-1:0] rsp1_result;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_control;
   logic         alu_zero;
   logic         busy;

   int n_cmp = 0;
   int n_bad = 0;
   bit last = 1'b1;

   alu_arbiter #(.WIDTH(W), .OPW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_f(
      input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return (a < b) ? 1 : 0;
         4'b1100: return ~(a | b);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_f(alu_a, alu_b, alu_control);
      alu_zero   = (alu_result == '0);
   end

   task automatic chk(input string tag,
                      input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] rnd_op();
      logic [3:0] tbl [8] = '{4'h0, 4'h1, 4'h2, 4'h6,
                              4'h7, 4'hC, 4'h3, 4'hF};
      return tbl[$urandom_range(0, 7)];
   endfunction

   // One full transaction; caller is at a negedge in IDLE.
   task automatic op(input bit v0, input bit v1,
                     input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [3:0] o0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input logic [3:0] o1, input int hold,
                     output logic [W-1:0] res, output bit z);
      bit w;
      logic [W-1:0] ea, eb;
      logic [3:0] eo;
      w = (v0 && v1) ? ~last : v1;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
      ea = w ? a1 : a0;
      eb = w ? b1 : b0;
      eo = w ? o1 : o0;
      res = alu_f(ea, eb, eo);
      z = (res == '0);
      #1;
      chk("req0_ready_grant", req0_ready, !w);
      chk("req1_ready_grant", req1_ready, w);
      chk("busy_idle", busy, 0);
      @(posedge clk); @(negedge clk);
      last = w;
      chk("busy_exec", busy, 1);
      chk("ready_exec", {req0_ready, req1_ready}, 0);
      chk("rsp_valid_exec", {rsp0_valid, rsp1_valid}, 0);
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_control", alu_control, eo);
      req0_a = $urandom; req0_b = $urandom; req0_op = rnd_op();
      req1_a = $urandom; req1_b = $urandom; req1_op = rnd_op();
      @(posedge clk); @(negedge clk);
      for (int i = 0; i <= hold; i++) begin
         chk("rsp0_valid", rsp0_valid, !w);
         chk("rsp1_valid", rsp1_valid, w);
         chk("rsp0_result", rsp0_result, res);
         chk("rsp1_result", rsp1_result, res);
         chk("rsp_zero", {rsp0_zero, rsp1_zero}, {z, z});
         chk("ready_resp", {req0_ready, req1_ready}, 0);
         chk("busy_resp", busy, 1);
         if (i < hold) begin
            @(posedge clk); @(negedge clk);
         end
      end
      if (w) rsp1_ready = 1'b1;
      else   rsp0_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      chk("busy_after", busy, 0);
      chk("rsp_valid_after", {rsp0_valid, rsp1_valid}, 0);
      chk("alu_a_hold", alu_a, ea);
   endtask

   logic [W-1:0] r;
   bit           zf;

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
      chk("rst_result", {rsp0_result, rsp1_result}, 0);
      chk("rst_zero", {rsp0_zero, rsp1_zero}, 0);
      chk("rst_alu", {alu_a, alu_b, alu_control}, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);

      op(1, 0, 5, 7, 4'b0010, 0, 0, 0, 0, r, zf);
      chk("add_5_7", r, 12);
      chk("add_zero", zf, 0);
      op(0, 1, 0, 0, 0, 9, 9, 4'b0110, 0, r, zf);
      chk("sub_9_9", r, 0);
      chk("sub_zero", zf, 1);
      op(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 1, 4'b0111, 0, r, zf);
      chk("sltu", r, 0);

      for (int i = 0; i < 8; i++) begin
         chk("tie_turn", last, (i % 2 == 0) ? 1 : 0);
         op(1, 1, $urandom, $urandom, rnd_op(),
            $urandom, $urandom, rnd_op(), 0, r, zf);
      end

      op(1, 0, 3, 4, 4'b0001, 0, 0, 0, 5, r, zf);
      chk("or_hold", r, 7);
      op(1, 0, 1, 2, 4'b0011, 0, 0, 0, 0, r, zf);
      chk("undef_res", r, 0);
      chk("undef_zero", zf, 1);

      for (int i = 0; i < 40; i++) begin
         int p;
         p = $urandom_range(1, 3);
         op(p[0], p[1], $urandom, $urandom, rnd_op(),
            $urandom, $urandom, rnd_op(),
            $urandom_range(0, 3), r, zf);
      end

      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_a = 11; req0_b = 22; req0_op = 4'b0010;
      @(posedge clk); @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", {req0_ready, req1_ready}, 0);
      chk("mid_rst_alu", {alu_a, alu_b, alu_control}, 0);
      chk("mid_rst_rsp", {rsp0_valid, rsp1_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      req0_valid = 1'b0;
      last = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_rsp", {rsp0_valid, rsp1_valid}, 0);
         chk("post_rst_busy", busy, 0);
      end
      op(1, 1, 20, 22, 4'b0010, 1, 1, 4'b0000, 0, r, zf);
      chk("post_rst_add", r, 42);
      req0_valid = 1'b0; req1_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
